multi_rate_clock_gen: RTL

Parametrised, runtime-programmable multi-channel clock divider. Produces NUM_CH independent 50%-duty divided clocks plus single-cycle tick enables from the master clock, and serves as the single rate source for VGA, 7-segment scan, game timer and character-animation logic. Adds per-channel enable, glitch-free divisor reprogramming through a valid/ready port, and a global phase-sync pulse.

---
 rtl/multi_rate_clock_gen_pkg.sv | 28 ++
 rtl/multi_rate_clock_gen_div_channel.sv | 91 +++++++++
 rtl/multi_rate_clock_gen.sv | 70 +++++++
 3 files changed

// File: rtl/multi_rate_clock_gen_pkg.sv
// multi_rate_clock_gen_pkg
// Shared rate constants for the multi-rate clock generator and the logic it
// feeds (VGA, 7-segment scan, game timer, character animation).
// CLK_HZ is the master clock. The *_HALF constants are half-periods in master
// clock cycles. DEFAULT_INIT_HALF packs them for a 4-channel generator,
// channel 0 in the LSBs. SIM_SCALE shrinks real-time rates so simulation
// stays short; simHalf() applies it and keeps the result at 1 or more.
package multi_rate_clock_gen_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;

  localparam logic [31:0] VGA_HALF  = 32'd2;
  localparam logic [31:0] SEG_HALF  = 32'd100_000;
  localparam logic [31:0] SEC_HALF  = 32'd50_000_000;
  localparam logic [31:0] CHAR_HALF = 32'd2_500_000;

  localparam int unsigned SIM_SCALE = 50_000;

  localparam logic [127:0] DEFAULT_INIT_HALF =
    {CHAR_HALF, SEC_HALF, SEG_HALF, VGA_HALF};

  function automatic logic [31:0] simHalf(input logic [31:0] h);
    logic [31:0] s;
    s = h / SIM_SCALE;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/multi_rate_clock_gen_div_channel.sv
// multi_rate_clock_gen_div_channel
// One divider channel. It holds the counter, the active half-period, a
// one-deep pending half-period slot, and the toggle and tick logic.
//   clk, rst  master clock; asynchronous active-low reset
//   en        run enable. When low, the channel is held at 0.
//   sync      phase-align: restart the half-period at 0 (only while enabled)
//   wrEn      accepted config write for this channel
//   wrHalf    new half-period (0 behaves as 1)
//   clkOut    divided clock, 50% duty, period 2*half
//   tick      one-cycle pulse in the first cycle clkOut reads 1
//   half      active half-period (status)
//   pendV     a pending half-period is waiting to be applied
module multi_rate_clock_gen_div_channel
  import multi_rate_clock_gen_pkg::*;
#(
  parameter int               CNT_W = 32,
  parameter logic [CNT_W-1:0] INIT  = CNT_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wrEn,
  input  logic [CNT_W-1:0] wrHalf,
  output logic             clkOut,
  output logic             tick,
  output logic [CNT_W-1:0] half,
  output logic             pendV
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pendHalf;
  logic             enQ;

  // A half-period of 0 runs as 1, so the terminal count never underflows.
  function automatic logic [CNT_W-1:0] termCount(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - 1'b1;
  endfunction

  // A pending half-period only ever switches in at a half-period boundary:
  // at a terminal count, at sync, or while the channel is stopped.
  // Accepting a write requires pendV low, and applying one requires pendV
  // high, so the write and the apply never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      clkOut   <= 1'b0;
      tick     <= 1'b0;
      half     <= INIT;
      pendHalf <= '0;
      pendV    <= 1'b0;
      enQ      <= 1'b0;
    end else begin
      enQ  <= en;
      tick <= 1'b0;
      if (wrEn) begin
        pendHalf <= wrHalf;
        pendV    <= 1'b1;
      end
      if (!en) begin
        cnt    <= '0;
        clkOut <= 1'b0;
        if (pendV) begin
          half  <= pendHalf;
          pendV <= 1'b0;
        end
      end else if (sync || !enQ) begin
        // The first enabled cycle, or a sync, holds the count at 0. The
        // first rising edge then lands exactly half cycles later, with no
        // runt pulse.
        cnt    <= '0;
        clkOut <= 1'b0;
        if (sync && pendV) begin
          half  <= pendHalf;
          pendV <= 1'b0;
        end
      end else if (cnt == termCount(half)) begin
        cnt    <= '0;
        clkOut <= ~clkOut;
        tick   <= ~clkOut;
        if (pendV) begin
          half  <= pendHalf;
          pendV <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_rate_clock_gen.sv
// multi_rate_clock_gen
// Runtime-programmable multi-channel clock divider. Produces NUM_CH
// independent 50%-duty divided clocks plus rising-edge tick enables.
//   clk, rst   master clock (100 MHz); asynchronous active-low reset
//   en         per-channel run enable
//   sync       phase-align pulse for all enabled channels
//   cfg_valid  divisor update request
//   cfg_ready  update can be accepted for cfg_ch (combinational)
//   cfg_ch     target channel; values >= NUM_CH are accepted and dropped
//   cfg_half   new half-period in clk cycles (0 behaves as 1)
//   clk_o      divided clocks, registered
//   tick_o     one-cycle pulse on each clk_o 0->1 edge
//   half_o     active half-period per channel, channel 0 in the LSBs
module multi_rate_clock_gen
  import multi_rate_clock_gen_pkg::*;
#(
  parameter int                      NUM_CH    = 4,
  parameter int                      CNT_W     = 32,
  parameter int                      CH_W      = 2,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_HALF = DEFAULT_INIT_HALF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH*CNT_W-1:0] half_o
);

  logic [NUM_CH-1:0] pendV;
  logic              accept;

  // Ready reflects only the target channel's pending slot. An out-of-range
  // channel leaves the default 1 in place, so the write is taken and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pendV[i];
    end
  end

  assign accept = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic wrEn;
    assign wrEn = accept && (cfg_ch == CH_W'(g));

    multi_rate_clock_gen_div_channel #(
      .CNT_W (CNT_W),
      .INIT  (INIT_HALF[g*CNT_W +: CNT_W])
    ) uChan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .sync   (sync),
      .wrEn   (wrEn),
      .wrHalf (cfg_half),
      .clkOut (clk_o[g]),
      .tick   (tick_o[g]),
      .half   (half_o[g*CNT_W +: CNT_W]),
      .pendV  (pendV[g])
    );
  end

endmodule
